// File: rtl/systolic_tile_ctrl_if.sv
// Handshake and buffer-control bundle between the tile sequencer and its
// surroundings (host start request, A/B read ports, C write port, array control).
interface systolic_tile_ctrl_if #(
   parameter int ARRAY_SIZE = 4,
   parameter int ADDR_W     = 16,
   parameter int K_W        = 9
);
   localparam int SEL_W = $clog2(ARRAY_SIZE);

   // host side
   logic                  start;
   logic [K_W-1:0]        k_len;
   logic [ADDR_W-1:0]     a_base;
   logic [ADDR_W-1:0]     b_base;
   logic [ADDR_W-1:0]     c_base;
   logic                  busy;
   logic                  done;

   // PE array and buffer side
   logic                  arr_clear;
   logic                  a_rd_en;
   logic [ADDR_W-1:0]     a_rd_addr;
   logic                  b_rd_en;
   logic [ADDR_W-1:0]     b_rd_addr;
   logic [ARRAY_SIZE-1:0] lane_mask;
   logic                  c_wr_en;
   logic [ADDR_W-1:0]     c_wr_addr;
   logic [SEL_W-1:0]      c_row_sel;

   // sequencer view
   modport master (
      input  start, k_len, a_base, b_base, c_base,
      output busy, done, arr_clear,
      output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, lane_mask,
      output c_wr_en, c_wr_addr, c_row_sel
   );

   // host / datapath view
   modport slave (
      output start, k_len, a_base, b_base, c_base,
      input  busy, done, arr_clear,
      input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, lane_mask,
      input  c_wr_en, c_wr_addr, c_row_sel
   );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one output-stationary SxS systolic tile: clear the array,
// stream skewed A/B operand words, wait for the wavefront to drain, then
// write the S result rows to the C buffer and pulse done.
module systolic_tile_ctrl #(
   parameter int ARRAY_SIZE = 4,
   parameter int ADDR_W     = 16,
   parameter int K_W        = 9,
   parameter int PE_LAT     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   systolic_tile_ctrl_if.master ctrl_if
);

   localparam int SEL_W = $clog2(ARRAY_SIZE);
   // wide enough for K + S - 2 and S + PE_LAT - 1
   localparam int CNT_W = K_W + $clog2(ARRAY_SIZE + PE_LAT) + 2;

   generate
      if (ARRAY_SIZE < 2) begin : g_bad_size
         $error("systolic_tile_ctrl: ARRAY_SIZE must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_FEED,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t                state_q;
   logic [K_W-1:0]        k_q;
   logic [ADDR_W-1:0]     a_base_q;
   logic [ADDR_W-1:0]     b_base_q;
   logic [ADDR_W-1:0]     c_base_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  a_rd_en_q;
   logic [ADDR_W-1:0]     a_rd_addr_q;
   logic                  b_rd_en_q;
   logic [ADDR_W-1:0]     b_rd_addr_q;
   logic [ARRAY_SIZE-1:0] lane_mask_q;
   logic                  c_wr_en_q;
   logic [ADDR_W-1:0]     c_wr_addr_q;
   logic [SEL_W-1:0]      c_row_sel_q;

   logic [CNT_W-1:0]      cnt_d;
   logic [ADDR_W-1:0]     cnt_addr_d;
   logic [ARRAY_SIZE-1:0] feed_mask_d;
   logic [CNT_W-1:0]      feed_last;
   logic [CNT_W-1:0]      drain_last;
   logic [CNT_W-1:0]      write_last;

   // phase end points and the incremented counter in address width
   always_comb begin
      cnt_d      = cnt_q + CNT_W'(1);
      cnt_addr_d = ADDR_W'(cnt_d);
      feed_last  = CNT_W'(k_q) + CNT_W'(ARRAY_SIZE - 2);
      drain_last = CNT_W'(ARRAY_SIZE + PE_LAT - 1);
      write_last = CNT_W'(ARRAY_SIZE - 1);
   end

   // edge lane i carries real data at feed step t iff i <= t < i + K
   always_comb begin
      feed_mask_d = '0;
      for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
         feed_mask_d[i] = (cnt_q >= CNT_W'(i)) &&
                          (cnt_q <  CNT_W'(i) + CNT_W'(k_q));
      end
   end

   // tile FSM with registered buffer strobes, addresses and lane mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         a_base_q    <= '0;
         b_base_q    <= '0;
         c_base_q    <= '0;
         cnt_q       <= '0;
         a_rd_en_q   <= 1'b0;
         a_rd_addr_q <= '0;
         b_rd_en_q   <= 1'b0;
         b_rd_addr_q <= '0;
         lane_mask_q <= '0;
         c_wr_en_q   <= 1'b0;
         c_wr_addr_q <= '0;
         c_row_sel_q <= '0;
      end else begin
         // strobes and buses idle unless a state below drives them
         a_rd_en_q   <= 1'b0;
         a_rd_addr_q <= '0;
         b_rd_en_q   <= 1'b0;
         b_rd_addr_q <= '0;
         lane_mask_q <= '0;
         c_wr_en_q   <= 1'b0;
         c_wr_addr_q <= '0;
         c_row_sel_q <= '0;

         unique case (state_q)
            ST_IDLE: begin
               if (ctrl_if.start) begin
                  k_q      <= ctrl_if.k_len;
                  a_base_q <= ctrl_if.a_base;
                  b_base_q <= ctrl_if.b_base;
                  c_base_q <= ctrl_if.c_base;
                  cnt_q    <= '0;
                  state_q  <= ST_START;
               end
            end

            ST_START: begin
               cnt_q <= '0;
               if (k_q != '0) begin
                  a_rd_en_q   <= 1'b1;
                  a_rd_addr_q <= a_base_q;
                  b_rd_en_q   <= 1'b1;
                  b_rd_addr_q <= b_base_q;
                  state_q     <= ST_FEED;
               end else begin
                  // empty reduction: cleared array is written out as zeros
                  c_wr_en_q   <= 1'b1;
                  c_wr_addr_q <= c_base_q;
                  state_q     <= ST_WRITE;
               end
            end

            ST_FEED: begin
               // mask of this read appears next cycle, alongside its data
               lane_mask_q <= feed_mask_d;
               if (cnt_q == feed_last) begin
                  cnt_q   <= '0;
                  state_q <= ST_DRAIN;
               end else begin
                  cnt_q       <= cnt_d;
                  a_rd_en_q   <= 1'b1;
                  a_rd_addr_q <= a_base_q + cnt_addr_d;
                  b_rd_en_q   <= 1'b1;
                  b_rd_addr_q <= b_base_q + cnt_addr_d;
               end
            end

            ST_DRAIN: begin
               if (cnt_q == drain_last) begin
                  cnt_q       <= '0;
                  c_wr_en_q   <= 1'b1;
                  c_wr_addr_q <= c_base_q;
                  state_q     <= ST_WRITE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_WRITE: begin
               if (cnt_q == write_last) begin
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q       <= cnt_d;
                  c_wr_en_q   <= 1'b1;
                  c_wr_addr_q <= c_base_q + cnt_addr_d;
                  c_row_sel_q <= SEL_W'(cnt_d);
               end
            end

            ST_DONE: begin
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // status and array clear decode directly from the state register
   assign ctrl_if.busy      = (state_q != ST_IDLE);
   assign ctrl_if.done      = (state_q == ST_DONE);
   assign ctrl_if.arr_clear = (state_q == ST_START);

   assign ctrl_if.a_rd_en   = a_rd_en_q;
   assign ctrl_if.a_rd_addr = a_rd_addr_q;
   assign ctrl_if.b_rd_en   = b_rd_en_q;
   assign ctrl_if.b_rd_addr = b_rd_addr_q;
   assign ctrl_if.lane_mask = lane_mask_q;
   assign ctrl_if.c_wr_en   = c_wr_en_q;
   assign ctrl_if.c_wr_addr = c_wr_addr_q;
   assign ctrl_if.c_row_sel = c_row_sel_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: per-cycle comparison against a schedule model,
// a table of tile summaries, an operand-delivery PE model, random tiles and
// a mid-tile reset.
module tb_systolic_tile_ctrl;

   localparam int S      = 4;
   localparam int AW     = 16;
   localparam int KW     = 9;
   localparam int PL     = 2;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          arr_clear;
      logic          a_rd_en;
      logic [AW-1:0] a_rd_addr;
      logic          b_rd_en;
      logic [AW-1:0] b_rd_addr;
      logic [S-1:0]  lane_mask;
      logic          c_wr_en;
      logic [AW-1:0] c_wr_addr;
      logic [1:0]    c_row_sel;
   } outs_t;

   typedef struct {
      logic [KW-1:0] k;
      logic [AW-1:0] a, b, c;
      int            poke;
      bit            pe_chk;
      int            exp_busy;
      int            exp_reads;
      logic [AW-1:0] exp_first_a, exp_last_a, exp_last_c;
   } vec_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   int   amat [S][S];
   int   bmat [S][S];
   int   aw   [S][16];
   int   bw   [16][S];
   int   cmem [S][S];

   systolic_tile_ctrl_if #(.ARRAY_SIZE(S), .ADDR_W(AW), .K_W(KW)) bus ();

   systolic_tile_ctrl #(
      .ARRAY_SIZE(S),
      .ADDR_W    (AW),
      .K_W       (KW),
      .PE_LAT    (PL)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ctrl_if(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outs_t sample();
      outs_t o;
      o.busy      = bus.busy;
      o.done      = bus.done;
      o.arr_clear = bus.arr_clear;
      o.a_rd_en   = bus.a_rd_en;
      o.a_rd_addr = bus.a_rd_addr;
      o.b_rd_en   = bus.b_rd_en;
      o.b_rd_addr = bus.b_rd_addr;
      o.lane_mask = bus.lane_mask;
      o.c_wr_en   = bus.c_wr_en;
      o.c_wr_addr = bus.c_wr_addr;
      o.c_row_sel = bus.c_row_sel;
      return o;
   endfunction

   // lane i valid at feed step t iff i <= t < i + k
   function automatic logic [S-1:0] mask_at(int t, int k);
      logic [S-1:0] m;
      m = '0;
      for (int i = 0; i < S; i++) m[i] = (i <= t) && (t < i + k);
      return m;
   endfunction

   function automatic int feed_len(int k);
      return (k > 0) ? k + S - 1 : 0;
   endfunction

   function automatic int drain_len(int k);
      return (k > 0) ? S + PL : 0;
   endfunction

   function automatic int tile_len(int k);
      return 1 + feed_len(k) + drain_len(k) + S + 1;
   endfunction

   // expected outputs at cycle n of a tile (n = 0 is the clear cycle)
   function automatic outs_t model_out(int n, int k, logic [AW-1:0] a,
                                       logic [AW-1:0] b, logic [AW-1:0] c);
      outs_t e;
      int    f0, d0, w0, t;
      e  = '0;
      f0 = 1;
      d0 = f0 + feed_len(k);
      w0 = d0 + drain_len(k);
      if (n < tile_len(k)) e.busy = 1'b1;
      if (n == 0) e.arr_clear = 1'b1;
      if (n >= f0 && n < d0) begin
         t           = n - f0;
         e.a_rd_en   = 1'b1;
         e.b_rd_en   = 1'b1;
         e.a_rd_addr = a + AW'(t);
         e.b_rd_addr = b + AW'(t);
         if (t > 0) e.lane_mask = mask_at(t - 1, k);
      end
      if (k > 0 && n == d0) e.lane_mask = mask_at(feed_len(k) - 1, k);
      if (n >= w0 && n < w0 + S) begin
         e.c_wr_en   = 1'b1;
         e.c_wr_addr = c + AW'(n - w0);
         e.c_row_sel = 2'(n - w0);
      end
      if (n == w0 + S) e.done = 1'b1;
      return e;
   endfunction

   task automatic check(input string name, input int n, input outs_t got, input outs_t exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, n, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Runs one tile: asserts start in the cycle following the caller's
   // current one, compares every busy cycle, and optionally feeds an
   // operand-delivery model of the PE array.
   task automatic run_tile(input logic [KW-1:0] k, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] c,
                           input int poke, input bit pe_chk,
                           output int busy_cnt, output int reads,
                           output logic [AW-1:0] first_a, output logic [AW-1:0] last_a,
                           output logic [AW-1:0] last_c);
      int            len, kk, t;
      outs_t         g, e;
      logic          prev_en;
      logic [AW-1:0] prev_a, prev_b, dt;
      busy_cnt = 0; reads = 0; first_a = '0; last_a = '0; last_c = '0;
      len = tile_len(int'(k));
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.k_len  = k;
      bus.a_base = a;
      bus.b_base = b;
      bus.c_base = c;
      @(negedge clk);
      check("idle_before_start", -1, sample(), '0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      prev_en = 1'b0; prev_a = '0; prev_b = '0;
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         g = sample();
         e = model_out(n, int'(k), a, b, c);
         check("tile_cycle", n, g, e);
         if (g.busy) busy_cnt++;
         if (g.a_rd_en) begin
            if (reads == 0) first_a = g.a_rd_addr;
            last_a = g.a_rd_addr;
            reads++;
         end
         if (g.c_wr_en) last_c = g.c_wr_addr;
         if (pe_chk) begin
            if (g.arr_clear) begin
               foreach (aw[i, j]) aw[i][j] = 0;
               foreach (bw[i, j]) bw[i][j] = 0;
               foreach (cmem[i, j]) cmem[i][j] = 0;
            end
            // data read last cycle arrives now, gated by this cycle's mask
            if (prev_en) begin
               dt = prev_a - a;
               t  = int'(dt);
               for (int i = 0; i < S; i++) begin
                  kk = t - i;
                  if (g.lane_mask[i] && kk >= 0 && kk < int'(k) && kk < S)
                     aw[i][kk] += amat[i][kk];
               end
               dt = prev_b - b;
               t  = int'(dt);
               for (int j = 0; j < S; j++) begin
                  kk = t - j;
                  if (g.lane_mask[j] && kk >= 0 && kk < int'(k) && kk < S)
                     bw[kk][j] += bmat[kk][j];
               end
            end
            if (g.c_wr_en) begin
               for (int j = 0; j < S; j++) begin
                  cmem[g.c_row_sel][j] = 0;
                  for (int q = 0; q < 16; q++)
                     cmem[g.c_row_sel][j] += aw[g.c_row_sel][q] * bw[q][j];
               end
            end
            prev_en = g.a_rd_en;
            prev_a  = g.a_rd_addr;
            prev_b  = g.b_rd_addr;
         end
         if (n == poke) begin
            bus.start  = 1'b1;
            bus.k_len  = k + 9'd3;
            bus.a_base = ~a;
            bus.b_base = ~b;
            bus.c_base = ~c;
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t          tbl [5];
      int            bc, rd;
      logic [AW-1:0] fa, la, lc, ra, rb, rc;
      logic [KW-1:0] rk;
      int            rp;

      vectors = 0; miscompares = 0;
      foreach (amat[i, j]) amat[i][j] = (i == j) ? 1 : 0;
      foreach (bmat[i, j]) bmat[i][j] = i * S + j + 1;

      //          k   a        b        c        poke pe  busy rd first    last     last_c
      tbl[0] = '{9'd4, 16'h0010, 16'h0020, 16'h0030, 3,  1, 19, 7, 16'h0010, 16'h0016, 16'h0033};
      tbl[1] = '{9'd4, 16'hFFFE, 16'h0100, 16'hFFFD, -1, 1, 19, 7, 16'hFFFE, 16'h0004, 16'h0000};
      tbl[2] = '{9'd0, 16'h0050, 16'h0060, 16'h0040, 2,  0, 6,  0, 16'h0000, 16'h0000, 16'h0043};
      tbl[3] = '{9'd1, 16'h1234, 16'h4321, 16'h2000, -1, 0, 16, 4, 16'h1234, 16'h1237, 16'h2003};
      tbl[4] = '{9'd9, 16'h0000, 16'h0800, 16'h0010, 5,  0, 24, 12, 16'h0000, 16'h000B, 16'h0013};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.k_len = '0;
      bus.a_base = '0; bus.b_base = '0; bus.c_base = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // idle after reset, no start
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check("reset_idle", n, sample(), '0);
      end

      // table of tiles, run back to back
      for (int v = 0; v < 5; v++) begin
         run_tile(tbl[v].k, tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].poke, tbl[v].pe_chk,
                  bc, rd, fa, la, lc);
         check_int("busy_cycles", bc, tbl[v].exp_busy);
         check_int("read_count", rd, tbl[v].exp_reads);
         check_int("first_a_addr", int'(fa), int'(tbl[v].exp_first_a));
         check_int("last_a_addr", int'(la), int'(tbl[v].exp_last_a));
         check_int("last_c_addr", int'(lc), int'(tbl[v].exp_last_c));
         if (tbl[v].pe_chk) begin
            for (int r = 0; r < S; r++)
               for (int j = 0; j < S; j++)
                  check_int("pe_c_equals_b", cmem[r][j], bmat[r][j]);
         end
      end

      // random tiles with random mid-tile start pulses
      for (int v = 0; v < 12; v++) begin
         rk = 9'($urandom_range(0, 12));
         ra = 16'($urandom());
         rb = 16'($urandom());
         rc = 16'($urandom());
         rp = $urandom_range(1, tile_len(int'(rk)) - 2);
         run_tile(rk, ra, rb, rc, rp, 1'b0, bc, rd, fa, la, lc);
         check_int("rand_busy_cycles", bc, tile_len(int'(rk)));
      end

      // reset during DRAIN of a K=3 tile
      @(posedge clk); #1;
      bus.start = 1'b1; bus.k_len = 9'd3;
      bus.a_base = 16'h0200; bus.b_base = 16'h0300; bus.c_base = 16'h0400;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      check("pre_reset_drain", 8, sample(), model_out(8, 3, 16'h0200, 16'h0300, 16'h0400));
      rst_n = 1'b0;
      #1;
      check("async_reset", 0, sample(), '0);
      for (int n = 1; n < 4; n++) begin
         @(negedge clk);
         check("held_reset", n, sample(), '0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset", 0, sample(), '0);
      run_tile(9'd4, 16'h0010, 16'h0020, 16'h0030, -1, 1'b1, bc, rd, fa, la, lc);
      check_int("post_reset_busy", bc, 19);
      for (int r = 0; r < S; r++)
         for (int j = 0; j < S; j++)
            check_int("post_reset_pe", cmem[r][j], bmat[r][j]);

      @(negedge clk);
      check("final_idle", 0, sample(), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
